lsu_xlate_stage: RTL and testbench
==================================

# lsu_xlate_stage

Load/store address-translation pipeline stage between the execute stage and the data cache. It accepts one memory request per cycle over a valid/ready handshake and drives the virtual address to the MMU data channel. In the same cycle it classifies address and TLB exceptions, computes byte enables and registers the translated request. It then offers that request to the data cache over a second valid/ready handshake. After an exception it holds off further requests until the pipeline is flushed.

## Interface
- N_ISSUE, 1, MMU data channels; only 1 is supported, and only channel 0 is used.
- EXC_HOLD, 1, when 1, block new requests after an excepting request is handed off, until `flush`.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  kill the in-flight request and clear HOLD.
- req_valid  in  1  request from execute.
- req_ready  out  1  stage can accept.
- req_vaddr  in  32  virtual byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_wdata  in  32  store data, passed through unchanged.
- mmu_vaddr  out  32 (virt_t)  combinational copy of req_vaddr, sent to MMU data_vaddr[0].
- mmu_resp  in  mmu_resp_t  MMU data_resp[0], valid in the same cycle.
- out_valid  out  1  registered request to the dcache.
- out_ready  in  1  dcache accepts.
- out_paddr  out  32  physical address.
- out_vaddr  out  32  original virtual address.
- out_we / out_size / out_wdata  out  1/2/32  registered copies of the request fields.
- out_be  out  4  byte enables.
- out_uncached  out  1  from mmu_resp.uncached.
- out_exc  out  1  request raised an exception; the dcache must not access memory.
- out_exc_code  out  5  MIPS ExcCode.
- out_refill  out  1  TLB refill; selects the refill vector.
- out_badvaddr  out  32  equals out_vaddr when out_exc is 1; 0 otherwise.

## Operation
- FSM states:
  - RUN: normal operation.
  - HOLD: entered when an entry with out_exc=1 handshakes (out_valid & out_ready) and EXC_HOLD=1.
  - HOLD → RUN only on `flush`.
- req_ready = (state==RUN) & ~flush & (~out_valid | out_ready).
- Accept = req_valid & req_ready.
  - On accept, the output register loads the classified request and out_valid becomes 1.
  - Otherwise, a handshake on the output clears out_valid.
- Misalignment:
  - half: vaddr[0]≠0.
  - word: vaddr[1:0]≠0.
- Exception priority, highest first (ExcCode, out_refill):
  1. Misaligned or mmu_resp.illegal: AdEL=4 for loads, AdES=5 for stores; refill=0.
  2. mmu_resp.miss: TLBL=2 / TLBS=3; refill=1.
  3. mmu_resp.inv: TLBL=2 / TLBS=3; refill=0.
  4. Store with ~mmu_resp.dirty: Mod=1; refill=0.
  - With no exception: out_exc=0 and exc_code=0.
- out_be, little-endian:
  - byte: 4'b0001 << vaddr[1:0].
  - half: 4'b0011 << vaddr[1:0].
  - word: 4'b1111.
  - Forced to 0 when out_exc=1.
- out_paddr = mmu_resp.paddr, also when excepting.
- flush:
  - Clears out_valid at the next edge regardless of out_ready, even if the dcache handshakes in the same cycle.
  - Sets state to RUN.
  - A request presented in a flush cycle is not accepted.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, state=RUN.
  - All registered outputs are 0: out_paddr, out_vaddr, out_wdata, out_be, out_exc, out_exc_code, out_refill, out_badvaddr, out_uncached, out_we, out_size.
- Reset mid-operation drops the in-flight request with no handshake.
- Latency:
  - Accept at edge N gives out_valid=1 after edge N.
  - Throughput is 1 request per cycle while out_ready=1.
- Stall: with out_valid & ~out_ready, all out_* hold stable and req_ready=0.
- Back-to-back: in the same cycle as an output handshake, a new request is accepted and replaces the entry with no bubble.
- The MMU path is combinational. mmu_resp must be sampled only in the accept cycle; it is not stored otherwise.
- In HOLD, req_ready=0 and out_valid stays 0 until flush. The flush cycle itself does not accept; acceptance resumes the cycle after flush.

## Structure
- Shared package, with mmu.svh:
  - Reuse the existing virt_t and mmu_resp_t.
  - Add mem_size_t (2-bit enum: SIZE_B, SIZE_H, SIZE_W).
  - Add an exccode_t constant set: EXC_MOD=1, EXC_TLBL=2, EXC_TLBS=3, EXC_ADEL=4, EXC_ADES=5.
  - Add lsu_xlate_req_t, a struct holding the out_* bundle.
- One combinational sub-module, lsu_exc_classify, maps (vaddr, we, size, mmu_resp) to {exc, exc_code, refill, be}.
- The top level holds the FSM and the output register.

## Test plan
- Aligned word load to 0x8000_1000 (kseg0, unmapped), mmu_resp.paddr=0x0000_1000, out_ready=1 → next cycle: out_valid=1, paddr=0x0000_1000, be=4'b1111, exc=0; back-to-back loads stream with no bubble.
- Half store to 0x0040_0003 → exc=1, code=5 (AdES), be=0, badvaddr=0x0040_0003; then HOLD: req_ready=0 until flush, and accepting again the cycle after flush.
- Mapped byte load to 0x0040_0002 with mmu_resp.miss=1 and inv=1 → code=2, refill=1 (miss beats inv); same access with only inv=1 → code=2, refill=0.
- Word store to mapped 0x0040_0010 with valid=1, dirty=0 → code=1 (Mod); with dirty=1 → exc=0, be=4'b1111.
- out_ready=0 for 3 cycles with req_valid=1 → outputs stable and req_ready=0; flush during the stall → out_valid=0 next cycle and the pending request is dropped.
- Assert rst low asynchronously mid-stall → out_valid and every out_* field read 0 immediately; first request after rst returns high completes normally.

Source files
------------

// File: rtl/lsu_xlate_pkg.sv
// Shared types for the LSU address-translation stage: MMU response,
// access size, MIPS exception codes and the registered request bundle.
package lsu_xlate_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] phys_t;

  typedef struct packed {
    phys_t paddr;
    logic  uncached;
    logic  valid;
    logic  dirty;
    logic  miss;
    logic  inv;
    logic  illegal;
  } mmu_resp_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef logic [4:0] exccode_t;

  localparam exccode_t EXC_NONE = 5'd0;
  localparam exccode_t EXC_MOD  = 5'd1;
  localparam exccode_t EXC_TLBL = 5'd2;
  localparam exccode_t EXC_TLBS = 5'd3;
  localparam exccode_t EXC_ADEL = 5'd4;
  localparam exccode_t EXC_ADES = 5'd5;

  typedef struct packed {
    phys_t      paddr;
    virt_t      vaddr;
    logic       we;
    logic [1:0] size;
    logic [31:0] wdata;
    logic [3:0] be;
    logic       uncached;
    logic       exc;
    exccode_t   exc_code;
    logic       refill;
    virt_t      badvaddr;
  } lsu_xlate_req_t;

  // Load and store flavours of the same exception class differ only by one code.
  function automatic exccode_t pick_code(input logic we, input exccode_t ld, input exccode_t st);
    return we ? st : ld;
  endfunction

endpackage

// File: rtl/lsu_exc_classify.sv
// Combinational classifier: alignment, MMU faults and byte enables for one access.
module lsu_exc_classify
  import lsu_xlate_pkg::*;
(
  input  virt_t      vaddr,
  input  logic       we,
  input  logic [1:0] size,
  input  mmu_resp_t  mmu_resp,
  output logic       exc,
  output exccode_t   exc_code,
  output logic       refill,
  output logic [3:0] be
);

  logic       misalign;
  logic [3:0] be_raw;

  // Translation result fields are consumed by the top-level register, not here.
  logic unused_mmu;
  assign unused_mmu = ^{mmu_resp.paddr, mmu_resp.uncached, mmu_resp.valid};

  // Size decode; encoding 3 behaves as a word access.
  always_comb begin
    misalign = 1'b0;
    be_raw   = 4'b1111;
    case (mem_size_t'(size))
      SIZE_B: be_raw = 4'b0001 << vaddr[1:0];
      SIZE_H: begin
        misalign = vaddr[0];
        be_raw   = 4'b0011 << vaddr[1:0];
      end
      default: begin
        misalign = |vaddr[1:0];
        be_raw   = 4'b1111;
      end
    endcase
  end

  // Priority: address error, TLB refill, TLB invalid, modify.
  always_comb begin
    exc      = 1'b1;
    exc_code = EXC_NONE;
    refill   = 1'b0;
    if (misalign || mmu_resp.illegal) begin
      exc_code = pick_code(we, EXC_ADEL, EXC_ADES);
    end else if (mmu_resp.miss) begin
      exc_code = pick_code(we, EXC_TLBL, EXC_TLBS);
      refill   = 1'b1;
    end else if (mmu_resp.inv) begin
      exc_code = pick_code(we, EXC_TLBL, EXC_TLBS);
    end else if (we && !mmu_resp.dirty) begin
      exc_code = EXC_MOD;
    end else begin
      exc = 1'b0;
    end
    be = exc ? 4'b0000 : be_raw;
  end

endmodule

// File: rtl/lsu_xlate_stage.sv
// LSU translation stage: accepts a request, translates via the MMU data
// channel, classifies exceptions and registers the result for the dcache.
// After an excepting entry is handed off, new requests wait for flush.
module lsu_xlate_stage
  import lsu_xlate_pkg::*;
#(
  parameter int unsigned N_ISSUE  = 1,
  parameter bit          EXC_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  virt_t       req_vaddr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output virt_t       mmu_vaddr,
  input  mmu_resp_t   mmu_resp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_paddr,
  output virt_t       out_vaddr,
  output logic        out_we,
  output logic [1:0]  out_size,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_be,
  output logic        out_uncached,
  output logic        out_exc,
  output logic [4:0]  out_exc_code,
  output logic        out_refill,
  output logic [31:0] out_badvaddr
);

  if (N_ISSUE != 1) begin : g_bad_n_issue
    $error("lsu_xlate_stage supports a single MMU data channel only");
  end

  typedef enum logic {RUN, HOLD} state_t;

  state_t         state_q, state_d;
  logic           valid_q, valid_d;
  lsu_xlate_req_t out_q, out_d;

  logic     c_exc;
  exccode_t c_code;
  logic     c_refill;
  logic [3:0] c_be;
  logic     accept;
  logic     out_hs;

  assign mmu_vaddr = req_vaddr;

  lsu_exc_classify u_classify (
    .vaddr    (req_vaddr),
    .we       (req_we),
    .size     (req_size),
    .mmu_resp (mmu_resp),
    .exc      (c_exc),
    .exc_code (c_code),
    .refill   (c_refill),
    .be       (c_be)
  );

  assign req_ready = (state_q == RUN) && !flush && (!valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  assign out_hs    = valid_q && out_ready;

  // Next-state: load on accept, drain on handshake, flush wins over both.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (accept) begin
      valid_d        = 1'b1;
      out_d.paddr    = mmu_resp.paddr;
      out_d.vaddr    = req_vaddr;
      out_d.we       = req_we;
      out_d.size     = req_size;
      out_d.wdata    = req_wdata;
      out_d.be       = c_be;
      out_d.uncached = mmu_resp.uncached;
      out_d.exc      = c_exc;
      out_d.exc_code = c_code;
      out_d.refill   = c_refill;
      out_d.badvaddr = c_exc ? req_vaddr : 32'h0;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
    if (out_hs && out_q.exc && EXC_HOLD) begin
      state_d = HOLD;
    end
    if (flush) begin
      valid_d = 1'b0;
      state_d = RUN;
    end
  end

  // State and output register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_paddr    = out_q.paddr;
  assign out_vaddr    = out_q.vaddr;
  assign out_we       = out_q.we;
  assign out_size     = out_q.size;
  assign out_wdata    = out_q.wdata;
  assign out_be       = out_q.be;
  assign out_uncached = out_q.uncached;
  assign out_exc      = out_q.exc;
  assign out_exc_code = out_q.exc_code;
  assign out_refill   = out_q.refill;
  assign out_badvaddr = out_q.badvaddr;

endmodule

// File: tb/tb_lsu_xlate_stage.sv
// Directed bench for lsu_xlate_stage with hand-computed expectations.
module tb_lsu_xlate_stage;
  import lsu_xlate_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  virt_t       req_vaddr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = '0;
  virt_t       mmu_vaddr;
  mmu_resp_t   mmu_resp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_paddr;
  virt_t       out_vaddr;
  logic        out_we;
  logic [1:0]  out_size;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_uncached;
  logic        out_exc;
  logic [4:0]  out_exc_code;
  logic        out_refill;
  logic [31:0] out_badvaddr;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_xlate_stage #(.N_ISSUE(1), .EXC_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata),
    .mmu_vaddr(mmu_vaddr), .mmu_resp(mmu_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_paddr(out_paddr), .out_vaddr(out_vaddr), .out_we(out_we), .out_size(out_size),
    .out_wdata(out_wdata), .out_be(out_be), .out_uncached(out_uncached),
    .out_exc(out_exc), .out_exc_code(out_exc_code), .out_refill(out_refill),
    .out_badvaddr(out_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] va, input logic we, input logic [1:0] sz,
                         input logic [31:0] wd);
    req_vaddr = va; req_we = we; req_size = sz; req_wdata = wd;
  endtask

  task automatic set_mmu(input logic [31:0] pa, input logic unc, input logic vld,
                         input logic dirty, input logic miss, input logic inv, input logic ill);
    mmu_resp.paddr = pa; mmu_resp.uncached = unc; mmu_resp.valid = vld;
    mmu_resp.dirty = dirty; mmu_resp.miss = miss; mmu_resp.inv = inv; mmu_resp.illegal = ill;
  endtask

  // Hand off an excepting entry, then flush out of HOLD.
  task automatic recover();
    req_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_paddr"}, out_paddr, 0);
    chk({tag, "_vaddr"}, out_vaddr, 0);
    chk({tag, "_wdata"}, out_wdata, 0);
    chk({tag, "_be"}, out_be, 0);
    chk({tag, "_exc"}, out_exc, 0);
    chk({tag, "_code"}, out_exc_code, 0);
    chk({tag, "_refill"}, out_refill, 0);
    chk({tag, "_bad"}, out_badvaddr, 0);
    chk({tag, "_unc"}, out_uncached, 0);
    chk({tag, "_we"}, out_we, 0);
    chk({tag, "_size"}, out_size, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk_all_zero("rst");
    chk("rst_ready", req_ready, 1);
    #6 rst = 1'b1;
    tick();

    // Aligned word loads, back-to-back
    set_req(32'h8000_1000, 1'b0, 2'd2, 32'h0);
    set_mmu(32'h0000_1000, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1; out_ready = 1'b1;
    #1 chk("ld_ready", req_ready, 1);
    chk("mmu_vaddr", mmu_vaddr, 32'h8000_1000);
    tick();
    chk("ld_valid", out_valid, 1);
    chk("ld_paddr", out_paddr, 32'h0000_1000);
    chk("ld_be", out_be, 4'b1111);
    chk("ld_exc", out_exc, 0);
    set_req(32'h8000_1002, 1'b0, 2'd1, 32'h0);
    set_mmu(32'h0000_1002, 0, 1, 0, 0, 0, 0);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_vaddr", out_vaddr, 32'h8000_1002);
    chk("half_be", out_be, 4'b1100);
    set_req(32'h8000_1008, 1'b0, 2'd3, 32'h0);
    set_mmu(32'h0000_1008, 0, 1, 0, 0, 0, 0);
    tick();
    chk("sz3_be", out_be, 4'b1111);
    chk("sz3_exc", out_exc, 0);
    req_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // Misaligned half store -> AdES, then HOLD until flush
    set_req(32'h0040_0003, 1'b1, 2'd1, 32'h1234_5678);
    set_mmu(32'h0001_2003, 0, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    chk("ades_exc", out_exc, 1);
    chk("ades_code", out_exc_code, 5);
    chk("ades_be", out_be, 0);
    chk("ades_bad", out_badvaddr, 32'h0040_0003);
    chk("ades_paddr", out_paddr, 32'h0001_2003);
    chk("ades_wdata", out_wdata, 32'h1234_5678);
    req_valid = 1'b0;
    tick();
    chk("hold_valid0", out_valid, 0);
    set_req(32'h8000_1010, 1'b0, 2'd2, 32'h0);
    set_mmu(32'h0000_1010, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1;
    #1 chk("hold_ready0", req_ready, 0);
    tick();
    chk("hold_valid1", out_valid, 0);
    chk("hold_ready1", req_ready, 0);
    flush = 1'b1;
    #1 chk("flush_ready", req_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0;
    #1 chk("post_flush_ready", req_ready, 1);
    tick();
    chk("resume_valid", out_valid, 1);
    chk("resume_vaddr", out_vaddr, 32'h8000_1010);
    req_valid = 1'b0;
    tick();

    // Mapped byte load: miss beats inv
    set_req(32'h0040_0002, 1'b0, 2'd0, 32'h0);
    set_mmu(32'h0002_0002, 0, 0, 0, 1, 1, 0);
    req_valid = 1'b1;
    tick();
    chk("miss_code", out_exc_code, 2);
    chk("miss_refill", out_refill, 1);
    chk("miss_be", out_be, 0);
    recover();
    set_mmu(32'h0002_0002, 0, 0, 0, 0, 1, 0);
    req_valid = 1'b1;
    tick();
    chk("inv_code", out_exc_code, 2);
    chk("inv_refill", out_refill, 0);
    recover();
    set_mmu(32'h0002_0002, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    chk("byte_exc", out_exc, 0);
    chk("byte_be", out_be, 4'b0100);
    req_valid = 1'b0;
    tick();

    // Word store: Mod when clean, clean pass when dirty
    set_req(32'h0040_0010, 1'b1, 2'd2, 32'hCAFE_F00D);
    set_mmu(32'h0003_0010, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    chk("mod_code", out_exc_code, 1);
    chk("mod_be", out_be, 0);
    recover();
    set_mmu(32'h0003_0010, 0, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    chk("st_exc", out_exc, 0);
    chk("st_code", out_exc_code, 0);
    chk("st_be", out_be, 4'b1111);
    chk("st_bad", out_badvaddr, 0);
    req_valid = 1'b0;
    tick();

    // Stall for three cycles, then flush drops the entry
    out_ready = 1'b0;
    set_req(32'h8000_2000, 1'b0, 2'd2, 32'h0);
    set_mmu(32'h0000_2000, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    set_req(32'h8000_2004, 1'b0, 2'd2, 32'h0);
    set_mmu(32'h0000_2004, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", req_ready, 0);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_vaddr", out_vaddr, 32'h8000_2000);
      chk("stall_paddr", out_paddr, 32'h0000_2000);
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("stall_flush_valid", out_valid, 0);
    tick();
    chk("stall_dropped", out_valid, 0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    set_req(32'h8000_3000, 1'b1, 2'd2, 32'hDEAD_BEEF);
    set_mmu(32'h0000_3000, 1, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    chk("pre_rst_wdata", out_wdata, 32'hDEAD_BEEF);
    chk("pre_rst_unc", out_uncached, 1);
    req_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_rst");
    #2 rst = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    set_req(32'h8000_1000, 1'b0, 2'd2, 32'h0);
    set_mmu(32'h0000_1000, 0, 1, 0, 0, 0, 0);
    req_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("post_rst_req_valid", out_valid, 1);
    chk("post_rst_paddr", out_paddr, 32'h0000_1000);
    req_valid = 1'b0;
    tick();
    chk("post_rst_drain", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
